// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divide sequencer: ALU select codes, FSM state encoding, default width.
package div_sequencer_pkg;

    localparam int unsigned XLEN_DEF = 32;

    localparam logic [4:0] ALU_DIV  = 5'b10100;
    localparam logic [4:0] ALU_DIVU = 5'b10101;
    localparam logic [4:0] ALU_REM  = 5'b10110;
    localparam logic [4:0] ALU_REMU = 5'b10111;
    localparam logic [2:0] ALU_DIV_GRP = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_RUN   = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic sgn;
        logic rem;
    } op_flags_t;

endpackage

// File: rtl/div_step.sv
// One iteration of a radix-2 restoring divider: shift {rem,quot} left and conditionally subtract.
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quot_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quot_o
);

    // Partial remainder needs one extra bit after the shift since it may reach 2*divisor-1.
    logic [XLEN:0] shifted;
    logic          ge;

    assign shifted = {rem_i, quot_i[XLEN-1]};
    assign ge      = shifted >= {1'b0, divisor_i};
    assign rem_o   = ge ? XLEN'(shifted - {1'b0, divisor_i}) : shifted[XLEN-1:0];
    assign quot_o  = {quot_i[XLEN-2:0], ge};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU controller that stalls the pipeline while a restoring divider iterates.
// Optional DIV_EARLY_OUT_EN: finish in CHECK when |dividend| < |divisor|.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      alusel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [XLEN-1:0] rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d;
    logic [XLEN-1:0] res_q, res_d;
    op_flags_t       flags_q, flags_d;

    logic            is_div;
    logic [XLEN-1:0] abs_a, abs_b, step_rem, step_quot, fix_rem, fix_quot;
    logic            a_neg, b_neg, sgn_ovf;

    assign is_div  = start & (alusel[4:2] == ALU_DIV_GRP);
    assign a_neg   = flags_q.sgn & a_q[XLEN-1];
    assign b_neg   = flags_q.sgn & b_q[XLEN-1];
    assign abs_a   = a_neg ? -a_q : a_q;
    assign abs_b   = b_neg ? -b_q : b_q;
    assign sgn_ovf = flags_q.sgn & (a_q == MIN_NEG) & (b_q == '1);
    assign fix_quot = (a_neg ^ b_neg) ? -quot_q : quot_q;
    assign fix_rem  = a_neg ? -rem_q : rem_q;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE: begin
                if (is_div && !flush) begin
                    a_d         = op_a;
                    b_d         = op_b;
                    flags_d.sgn = ~alusel[0];
                    flags_d.rem = alusel[1];
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (b_q == '0) begin
                    res_d   = flags_q.rem ? a_q : '1;
                    state_d = S_DONE;
                end else if (sgn_ovf) begin
                    res_d   = flags_q.rem ? '0 : MIN_NEG;
                    state_d = S_DONE;
`ifdef DIV_EARLY_OUT_EN
                end else if (abs_a < abs_b) begin
                    res_d   = flags_q.rem ? a_q : '0;
                    state_d = S_DONE;
`endif
                end else begin
                    rem_d   = '0;
                    quot_d  = abs_a;
                    dvs_d   = abs_b;
                    cnt_d   = CNT_W'(XLEN);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d  = step_rem;
                    quot_d = step_quot;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIXUP;
                    end
                end
            end
            S_FIXUP: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    res_d   = flags_q.rem ? fix_rem : fix_quot;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    // Stall covers the accepting IDLE cycle so EX holds the divide until DONE.
    assign stall  = ((state_q == S_IDLE) & is_div & ~flush) |
                    (state_q == S_CHECK) | (state_q == S_RUN) | (state_q == S_FIXUP);
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = res_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus randomized divides against an arithmetic model.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  alusel;
    logic [31:0] op_a, op_b;
    logic        flush;
    logic        stall, busy, done;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_res = '0;

    div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .alusel (alusel),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics computed with 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [4:0] code, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] tmp;
        if (b == 32'd0) return code[1] ? a : 32'hFFFF_FFFF;
        if (!code[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            tmp = code[1] ? 64'(r) : 64'(q);
            return tmp[31:0];
        end
        return code[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb;
        if (b == 32'd0) return 2;
        if (!code[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        ma = code[0] ? longint'(a) : longint'($signed(a));
        mb = code[0] ? longint'(b) : longint'($signed(b));
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 2;
`endif
        return 35;
    endfunction

    // abort_kind: 0 none, 1 flush, 2 reset; applied after abort_at cycles.
    task automatic do_op(input string tag, input logic [4:0] code, input logic [31:0] a,
                         input logic [31:0] b, input int abort_at, input int abort_kind);
        logic [31:0] exp_res;
        int exp_lat, cyc, stalls;
        bit got_done, busy_ok;
        exp_res = ref_result(code, a, b);
        exp_lat = ref_lat(code, a, b);
        @(negedge clk);
        start = 1'b1; alusel = code; op_a = a; op_b = b;
        #1;
        stalls = stall ? 1 : 0;
        cyc = 0; got_done = 1'b0; busy_ok = 1'b1;
        while (!got_done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (done) got_done = 1'b1;
            else begin
                if (stall) stalls++;
                if (!busy) busy_ok = 1'b0;
            end
            if (!got_done && abort_kind != 0 && cyc == abort_at) begin
                @(negedge clk);
                start = 1'b0;
                if (abort_kind == 2) begin
                    rst = 1'b0;
                    #1;
                    check({tag, "_rst_stall"}, 32'(stall), 32'd0);
                    check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                    check({tag, "_rst_done"}, 32'(done), 32'd0);
                    check({tag, "_rst_result"}, result, 32'd0);
                    last_res = '0;
                    @(negedge clk);
                    rst = 1'b1;
                end else begin
                    flush = 1'b1;
                    @(posedge clk); #1;
                    check({tag, "_flush_busy"}, 32'(busy), 32'd0);
                    check({tag, "_flush_done"}, 32'(done), 32'd0);
                    check({tag, "_flush_result"}, result, last_res);
                    @(negedge clk);
                    flush = 1'b0;
                end
                return;
            end
        end
        check({tag, "_done_seen"}, 32'(got_done), 32'd1);
        if (!got_done) begin
            start = 1'b0;
            return;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
        check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
        check({tag, "_stall_at_done"}, 32'(stall), 32'd0);
        check({tag, "_result"}, result, exp_res);
        last_res = exp_res;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_result_hold"}, result, last_res);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        rst = 1'b0; start = 1'b0; alusel = '0; op_a = '0; op_b = '0; flush = 1'b0;
        #12;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        do_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 0, 0);
        do_op("remu_100_7", ALU_REMU, 32'd100, 32'd7, 0, 0);
        do_op("div_m7_2", ALU_DIV, -32'd7, 32'd2, 0, 0);
        do_op("rem_m7_2", ALU_REM, -32'd7, 32'd2, 0, 0);
        do_op("div_7_m2", ALU_DIV, 32'd7, -32'd2, 0, 0);
        do_op("div_5_0", ALU_DIV, 32'd5, 32'd0, 0, 0);
        do_op("remu_5_0", ALU_REMU, 32'd5, 32'd0, 0, 0);
        do_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op("divu_3_10", ALU_DIVU, 32'd3, 32'd10, 0, 0);
        do_op("remu_3_10", ALU_REMU, 32'd3, 32'd10, 0, 0);

        // Non-divide code never stalls.
        @(negedge clk);
        start = 1'b1; alusel = 5'b00000; op_a = 32'd1; op_b = 32'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("add_stall", 32'(stall), 32'd0);
            check("add_busy", 32'(busy), 32'd0);
            check("add_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        start = 1'b0;

        // Flush coincident with start in IDLE: not accepted.
        @(negedge clk);
        start = 1'b1; alusel = ALU_DIV; op_a = 32'd50; op_b = 32'd5; flush = 1'b1;
        #1;
        check("flush_start_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check("flush_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;

        do_op("divu_flush", ALU_DIVU, 32'd1000, 32'd3, 10, 1);
        do_op("divu_9_3", ALU_DIVU, 32'd9, 32'd3, 0, 0);
        do_op("div_rst", ALU_DIV, 32'd12345, 32'd17, 22, 2);
        do_op("rem_after_rst", ALU_REM, -32'd100, 32'd7, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [4:0]  code;
            logic [31:0] a, b;
            code = {ALU_DIV_GRP, 2'($urandom_range(0, 3))};
            a = pick_operand();
            b = pick_operand();
            do_op("rand", code, a, b, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
